booth_r4_mult: RTL and testbench
================================

BOOTH_R4_MULT -- requirements
Module: booth_r4_mult

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, giving the operand width in bits; legal values are even and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiply.
REQ-005 The block SHALL have port signed_mode, input, 1 bit: 1 treats operands as two's complement, 0 as unsigned.
REQ-006 The block SHALL have port M, input, WIDTH bits: the multiplicand.
REQ-007 The block SHALL have port Q, input, WIDTH bits: the multiplier.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a multiply is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse when Z becomes valid.
REQ-010 The block SHALL have port Z, output, 2*WIDTH bits: the product.

Function
REQ-011 The state machine SHALL have three states: IDLE, CALC and DONE.
REQ-012 Transitions SHALL be IDLE->CALC on start, CALC->DONE after the last iteration, DONE->CALC on start, and DONE->IDLE otherwise.
REQ-013 On a start accepted in IDLE or DONE, M, Q and signed_mode SHALL be captured in that cycle; later input changes SHALL have no effect on the running multiply.
REQ-014 Captured operands SHALL be extended to WIDTH+2 bits: sign-extended when signed_mode=1, zero-extended when signed_mode=0.
REQ-015 The accumulator A (WIDTH+2 bits) and the extra low bit Q_-1 SHALL be cleared at capture.
REQ-016 Each CALC cycle SHALL perform one radix-4 Booth iteration using the recoding {Q[1],Q[0],Q_-1}, as follows:
- 000 or 111: add 0
- 001 or 010: add +M
- 011: add +2M
- 100: add -2M
- 101 or 110: add -M
REQ-017 After each add, {A,Q,Q_-1} SHALL be arithmetic-shifted right by 2 bits.
REQ-018 All add/subtract arithmetic SHALL be done at WIDTH+2 bits, so that ±2M of the most negative or largest operand never overflows.
REQ-019 CALC SHALL last exactly N=(WIDTH+2)/2 cycles, counted by an iteration counter cleared at capture.
REQ-020 With start sampled high at edge k, busy SHALL be high from edge k+1 to edge k+N.
REQ-021 done SHALL be high for exactly the one cycle following edge k+N+1, i.e. while in DONE.
REQ-022 Z SHALL be loaded with the low 2*WIDTH bits of {A,Q} on entering DONE, and SHALL hold until the next result is loaded or reset occurs.
REQ-023 A start sampled while in CALC SHALL be ignored: no restart and no effect on the result.
REQ-024 A start sampled in the DONE cycle SHALL be accepted, giving back-to-back operation; done SHALL still pulse for the finished result.
REQ-025 Z SHALL be exact for all operand pairs in both modes, including the most negative operand in signed mode and all-ones in unsigned mode.

Reset
REQ-026 While rst is high at a clock edge, the state SHALL become IDLE, and busy, done, Z, A, Q_-1 and the counter SHALL all become 0.
REQ-027 Reset SHALL override start in the same cycle.
REQ-028 A reset asserted during CALC SHALL abort the operation; no done pulse SHALL follow.

Verification (WIDTH=6)
REQ-029 Scenario 1: signed_mode=1, M=6'b100000 (-32), Q=6'b100000 -> done at edge k+5, Z=12'h400 (+1024).
REQ-030 Scenario 2: signed_mode=1, M=-32, Q=31 -> Z=12'hC20 (-992); with the operands swapped, Z is the same.
REQ-031 Scenario 3: signed_mode=0, M=63, Q=63 -> Z=12'hF81 (3969); signed_mode=1 with the same bits -> Z=12'h001.
REQ-032 Scenario 4: start held high continuously with changing operands -> only the operands sampled in IDLE/DONE are used; done pulses every 5 cycles; busy never drops during CALC.
REQ-033 Scenario 5: rst asserted on the 2nd CALC cycle -> the next cycle has busy=0, done=0, Z=0; no done pulse follows; the next start gives a correct product.
REQ-034 Scenario 6: a random sweep of 10,000 pairs in both modes -> Z equals the reference product every time; Z is stable between done pulses.

Source files
------------

// File: rtl/booth_r4_mult.sv
// Radix-4 Booth multiplier, one iteration per clock.
// Handles signed and unsigned operands by extending both to WIDTH+2 bits
// before iterating. N = (WIDTH+2)/2 iterations produce the product.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; Z holds the last result
// CALC  | one Booth iteration per cycle, N cycles total
// DONE  | Z was just loaded; done pulses; a start here is accepted
module booth_r4_mult #(
    parameter int WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     M,
    input  logic [WIDTH-1:0]     Q,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   Z
);

    // Extended operand width. The extra headroom keeps the accumulator from
    // overflowing on +/-2M, even for the largest unsigned or most negative
    // signed multiplicand.
    localparam int XW = WIDTH + 2;
    localparam int N  = XW / 2;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [XW-1:0]       r_m;
    logic [XW-1:0]       r_q;
    logic [XW-1:0]       r_a;
    logic                r_qm1;
    logic [CW-1:0]       r_cnt;
    logic [2*WIDTH-1:0]  r_z;

    logic                w_accept;
    logic                w_last;
    logic [XW-1:0]       w_m_ext;
    logic [XW-1:0]       w_q_ext;
    logic [XW-1:0]       w_m2;
    logic [XW-1:0]       w_neg_m;
    logic [XW-1:0]       w_neg_m2;
    logic [XW-1:0]       w_addend;
    logic [XW-1:0]       w_sum;
    logic [2*XW:0]       w_shifted;

    // A start can only be taken when no multiply is running.
    assign w_accept = start && (r_state != CALC);
    assign w_last   = (r_cnt == CW'(N - 1));

    assign w_m_ext  = signed_mode ? {{2{M[WIDTH-1]}}, M} : {2'b00, M};
    assign w_q_ext  = signed_mode ? {{2{Q[WIDTH-1]}}, Q} : {2'b00, Q};

    assign w_m2     = {r_m[XW-2:0], 1'b0};
    assign w_neg_m  = -r_m;
    assign w_neg_m2 = -w_m2;

    assign busy = (r_state == CALC);
    assign done = (r_state == DONE);
    assign Z    = r_z;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = CALC;
            CALC:    if (w_last) w_next_state = DONE;
            DONE:    w_next_state = start ? CALC : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Booth digit selection from {Q[1], Q[0], Q_-1}, add, then arithmetic
    // shift of {A, Q, Q_-1} right by two.
    always_comb begin
        w_addend = '0;
        case ({r_q[1:0], r_qm1})
            3'b001, 3'b010: w_addend = r_m;
            3'b011:         w_addend = w_m2;
            3'b100:         w_addend = w_neg_m2;
            3'b101, 3'b110: w_addend = w_neg_m;
            default:        w_addend = '0;
        endcase
        w_sum     = r_a + w_addend;
        w_shifted = {{2{w_sum[XW-1]}}, w_sum, r_q[XW-1:1]};
    end

    // Operand capture, iteration and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m   <= '0;
            r_q   <= '0;
            r_a   <= '0;
            r_qm1 <= 1'b0;
            r_cnt <= '0;
            r_z   <= '0;
        end else if (w_accept) begin
            r_m   <= w_m_ext;
            r_q   <= w_q_ext;
            r_a   <= '0;
            r_qm1 <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == CALC) begin
            r_a   <= w_shifted[2*XW:XW+1];
            r_q   <= w_shifted[XW:1];
            r_qm1 <= w_shifted[0];
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_z <= w_shifted[2*WIDTH:1];
            end
        end
    end

endmodule

// File: tb/tb_booth_r4_mult.sv
// Directed and swept checks of booth_r4_mult at WIDTH=6.
module tb_booth_r4_mult;

    localparam int W = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            signed_mode;
    logic [W-1:0]    M;
    logic [W-1:0]    Q;
    logic            busy;
    logic            done;
    logic [2*W-1:0]  Z;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic           sm;
        logic [W-1:0]   m;
        logic [W-1:0]   q;
        logic [2*W-1:0] z;
    } vec_t;

    vec_t vecs [12];

    booth_r4_mult #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .M           (M),
        .Q           (Q),
        .busy        (busy),
        .done        (done),
        .Z           (Z)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2*W-1:0] ref_prod(input logic sm, input logic [W-1:0] m,
                                                 input logic [W-1:0] q);
        int a;
        int b;
        a = int'(m);
        b = int'(q);
        if (sm && m[W-1]) a = a - 64;
        if (sm && q[W-1]) b = b - 64;
        return 12'(a * b);
    endfunction

    // Launch one multiply and wait for done; scrambles inputs after capture.
    // lat is the number of falling edges until done is seen, 0 on timeout.
    task automatic do_mult(input logic sm, input logic [W-1:0] m, input logic [W-1:0] q,
                           output logic [2*W-1:0] z, output int lat);
        @(negedge clk);
        signed_mode = sm;
        M           = m;
        Q           = q;
        start       = 1'b1;
        lat         = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start       = 1'b0;
                M           = ~m;
                Q           = q ^ 6'h15;
                signed_mode = ~sm;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        z = Z;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; signed_mode = 1'b1; M = 6'h20; Q = 6'h20;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++;
        if (Z !== 12'h000) begin n_fail++; $display("FAIL reset_z: got %h want 000", Z); end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_start: busy %b want 0", busy); end
    endtask

    task automatic test_timing;
        logic [11:0] z_exp;
        z_exp = 12'h400;
        @(negedge clk);
        signed_mode = 1'b1; M = 6'b100000; Q = 6'b100000; start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            n_checks++;
            if (busy !== (c <= 4)) begin
                n_fail++; $display("FAIL timing_busy c=%0d: got %b want %b", c, busy, (c <= 4));
            end
            n_checks++;
            if (done !== (c == 5)) begin
                n_fail++; $display("FAIL timing_done c=%0d: got %b want %b", c, done, (c == 5));
            end
            if (c >= 5) begin
                n_checks++;
                if (Z !== z_exp) begin n_fail++; $display("FAIL timing_z c=%0d: got %h want %h", c, Z, z_exp); end
            end
        end
    endtask

    task automatic test_directed;
        logic [11:0] z;
        int          lat;
        vecs = '{
            '{1'b1, 6'b100000, 6'b100000, 12'h400},
            '{1'b1, 6'b100000, 6'b011111, 12'hC20},
            '{1'b1, 6'b011111, 6'b100000, 12'hC20},
            '{1'b0, 6'b111111, 6'b111111, 12'hF81},
            '{1'b1, 6'b111111, 6'b111111, 12'h001},
            '{1'b0, 6'b111111, 6'b000001, 12'h03F},
            '{1'b1, 6'b000101, 6'b111101, 12'hFF1},
            '{1'b0, 6'b100000, 6'b100000, 12'h400},
            '{1'b1, 6'b011111, 6'b011111, 12'h3C1},
            '{1'b0, 6'b111111, 6'b100000, 12'h7E0},
            '{1'b0, 6'b000000, 6'b101010, 12'h000},
            '{1'b1, 6'b100000, 6'b000001, 12'hFE0}
        };
        foreach (vecs[i]) begin
            do_mult(vecs[i].sm, vecs[i].m, vecs[i].q, z, lat);
            n_checks++;
            if (lat !== 5) begin n_fail++; $display("FAIL directed_lat[%0d]: got %0d want 5", i, lat); end
            n_checks++;
            if (z !== vecs[i].z) begin
                n_fail++; $display("FAIL directed_z[%0d]: got %h want %h", i, z, vecs[i].z);
            end
        end
    endtask

    task automatic test_start_in_calc;
        int lat;
        @(negedge clk);
        signed_mode = 1'b1; M = 6'b100000; Q = 6'b011111; start = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            M = 6'b000101; Q = 6'b111101; signed_mode = 1'b0;
            if (done) begin lat = i; start = 1'b0; break; end
        end
        n_checks++;
        if (lat !== 5) begin n_fail++; $display("FAIL calc_start_lat: got %0d want 5", lat); end
        n_checks++;
        if (Z !== 12'hC20) begin n_fail++; $display("FAIL calc_start_z: got %h want C20", Z); end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL calc_start_idle: busy %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        logic exp_busy;
        logic exp_done;
        for (int c = 0; c <= 16; c++) begin
            if (c > 0) @(negedge clk);
            if (c >= 1) begin
                exp_busy = (c <= 15) && (c % 5 != 0);
                exp_done = (c <= 15) && (c % 5 == 0);
                n_checks++;
                if (busy !== exp_busy) begin n_fail++; $display("FAIL b2b_busy c=%0d: got %b want %b", c, busy, exp_busy); end
                n_checks++;
                if (done !== exp_done) begin n_fail++; $display("FAIL b2b_done c=%0d: got %b want %b", c, done, exp_done); end
                if (c >= 5 && c <= 9) begin
                    n_checks++;
                    if (Z !== 12'h400) begin n_fail++; $display("FAIL b2b_z c=%0d: got %h want 400", c, Z); end
                end
                if (c == 10) begin
                    n_checks++;
                    if (Z !== 12'hF81) begin n_fail++; $display("FAIL b2b_z c=10: got %h want F81", Z); end
                end
                if (c == 15) begin
                    n_checks++;
                    if (Z !== 12'hFF1) begin n_fail++; $display("FAIL b2b_z c=15: got %h want FF1", Z); end
                end
            end
            start = (c <= 10);
            if (c == 0) begin
                signed_mode = 1'b1; M = 6'b100000; Q = 6'b100000;
            end else if (c == 5) begin
                signed_mode = 1'b0; M = 6'b111111; Q = 6'b111111;
            end else if (c == 10) begin
                signed_mode = 1'b1; M = 6'b000101; Q = 6'b111101;
            end else begin
                signed_mode = c[0]; M = 6'(c * 7); Q = 6'(c * 11);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_abort;
        logic        saw_done;
        logic [11:0] z;
        int          lat;
        @(negedge clk);
        signed_mode = 1'b0; M = 6'b111111; Q = 6'b111111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_pre: got %b want 1", busy); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", done); end
        n_checks++;
        if (Z !== 12'h000) begin n_fail++; $display("FAIL abort_z: got %h want 000", Z); end
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b want 0", saw_done); end
        do_mult(1'b0, 6'b101101, 6'b011011, z, lat);
        n_checks++;
        if (lat !== 5) begin n_fail++; $display("FAIL abort_after_lat: got %0d want 5", lat); end
        n_checks++;
        if (z !== 12'h4BF) begin n_fail++; $display("FAIL abort_after_z: got %h want 4BF", z); end
    endtask

    task automatic test_sweep;
        logic        sm;
        logic [5:0]  m;
        logic [5:0]  q;
        logic [11:0] z;
        logic [11:0] z_exp;
        int          lat;
        int          printed;
        printed = 0;
        for (int i = 0; i < 10000; i++) begin
            sm = 1'($urandom_range(0, 1));
            m  = 6'($urandom_range(0, 63));
            q  = 6'($urandom_range(0, 63));
            z_exp = ref_prod(sm, m, q);
            do_mult(sm, m, q, z, lat);
            n_checks++;
            if (z !== z_exp || lat !== 5) begin
                n_fail++;
                if (printed < 10) begin
                    printed++;
                    $display("FAIL sweep[%0d] sm=%b m=%h q=%h: got z=%h lat=%0d want z=%h lat=5",
                             i, sm, m, q, z, lat, z_exp);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; M = '0; Q = '0;
        test_reset();
        test_timing();
        test_directed();
        test_start_in_calc();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
